// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer: opcodes, flag bit positions,
// issuer FSM state encoding and the opcode legality helper.
package alu_pkg;

  localparam logic [3:0] OP_MIN   = 4'd0;
  localparam logic [3:0] OP_SRL   = 4'd1;
  localparam logic [3:0] OP_ROR   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_PASSB = 4'd5;
  localparam logic [3:0] OP_NOR   = 4'd6;
  localparam logic [3:0] OP_SGE   = 4'd7;
  localparam logic [3:0] OP_SLL   = 4'd8;

  localparam int FLAG_CARRY = 0;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_SIGN  = 3;

  localparam int CNT_W = 4;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  function automatic logic op_is_legal(input logic [3:0] op, input int max_op);
    return (int'({28'd0, op}) <= max_op);
  endfunction

endpackage

// File: rtl/alu_issue_wait_ctr.sv
// Loadable down-counter that times how long the ALU inputs are held before
// the result is captured; done is high while the count is zero.
module alu_issue_wait_ctr
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // next count: load wins over decrement, decrement stops at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues tagged commands to an attached ALU, holds its inputs for ALU_LAT+1
// cycles, then returns result/flags as a tagged response. Optional statistics
// counters are enabled by defining ALU_ISSUER_STATS_EN.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int W       = 128,
  parameter int SHW     = 5,
  parameter int TAGW    = 4,
  parameter int ALU_LAT = 0,
  parameter int MAX_OP  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [3:0]      cmd_opcode,
  input  logic [W-1:0]    cmd_a,
  input  logic [W-1:0]    cmd_b,
  input  logic [SHW-1:0]  cmd_shift,
  input  logic [TAGW-1:0] cmd_tag,
  output logic [3:0]      alu_opcode,
  output logic [W-1:0]    alu_input1,
  output logic [W-1:0]    alu_input2,
  output logic [SHW-1:0]  alu_shift,
  input  logic [W-1:0]    alu_result,
  input  logic [3:0]      alu_flags,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [W-1:0]    rsp_result,
  output logic [3:0]      rsp_flags,
  output logic            rsp_err,
  output logic [TAGW-1:0] rsp_tag,
  output logic            busy
`ifdef ALU_ISSUER_STATS_EN
  ,
  output logic [31:0]     stat_cmd_cnt,
  output logic [15:0]     stat_err_cnt
`endif
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ALU_LAT);

  state_t          state_d, state_q;
  logic [3:0]      alu_opcode_d, alu_opcode_q;
  logic [W-1:0]    alu_input1_d, alu_input1_q;
  logic [W-1:0]    alu_input2_d, alu_input2_q;
  logic [SHW-1:0]  alu_shift_d, alu_shift_q;
  logic [TAGW-1:0] tag_d, tag_q;
  logic            rsp_valid_d, rsp_valid_q;
  logic [W-1:0]    rsp_result_d, rsp_result_q;
  logic [3:0]      rsp_flags_d, rsp_flags_q;
  logic            rsp_err_d, rsp_err_q;
  logic            busy_d, busy_q;

  logic accept;
  logic legal;
  logic ctr_load;
  logic ctr_dec;
  logic ctr_done;

  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign legal     = op_is_legal(cmd_opcode, MAX_OP);

  alu_issue_wait_ctr u_wait_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .load_val (LAT_LOAD),
    .dec      (ctr_dec),
    .done     (ctr_done)
  );

  // issuer FSM next-state and output-register next values
  always_comb begin
    state_d      = state_q;
    alu_opcode_d = alu_opcode_q;
    alu_input1_d = alu_input1_q;
    alu_input2_d = alu_input2_q;
    alu_shift_d  = alu_shift_q;
    tag_d        = tag_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;
    ctr_load     = 1'b0;
    ctr_dec      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          tag_d = cmd_tag;
          if (legal) begin
            alu_opcode_d = cmd_opcode;
            alu_input1_d = cmd_a;
            alu_input2_d = cmd_b;
            alu_shift_d  = cmd_shift;
            ctr_load     = 1'b1;
            state_d      = ST_WAIT;
          end else begin
            // illegal opcode answers at once; the ALU keeps its previous inputs
            rsp_result_d            = {W{1'b0}};
            rsp_flags_d             = 4'b0000;
            rsp_flags_d[FLAG_ZERO]  = 1'b1;
            rsp_err_d               = 1'b1;
            rsp_valid_d             = 1'b1;
            state_d                 = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (ctr_done) begin
          rsp_result_d = alu_result;
          rsp_flags_d  = alu_flags;
          rsp_err_d    = 1'b0;
          rsp_valid_d  = 1'b1;
          state_d      = ST_RESP;
        end else begin
          ctr_dec = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      alu_opcode_q <= 4'd0;
      alu_input1_q <= {W{1'b0}};
      alu_input2_q <= {W{1'b0}};
      alu_shift_q  <= {SHW{1'b0}};
      tag_q        <= {TAGW{1'b0}};
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= {W{1'b0}};
      rsp_flags_q  <= 4'd0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_opcode_q <= alu_opcode_d;
      alu_input1_q <= alu_input1_d;
      alu_input2_q <= alu_input2_d;
      alu_shift_q  <= alu_shift_d;
      tag_q        <= tag_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign alu_opcode = alu_opcode_q;
  assign alu_input1 = alu_input1_q;
  assign alu_input2 = alu_input2_q;
  assign alu_shift  = alu_shift_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_tag    = tag_q;
  assign busy       = busy_q;

`ifdef ALU_ISSUER_STATS_EN
  logic [31:0] stat_cmd_d, stat_cmd_q;
  logic [15:0] stat_err_d, stat_err_q;

  // saturating accept / illegal-accept counters
  always_comb begin
    stat_cmd_d = stat_cmd_q;
    stat_err_d = stat_err_q;
    if (accept && (stat_cmd_q != 32'hFFFF_FFFF)) begin
      stat_cmd_d = stat_cmd_q + 32'd1;
    end else begin
      stat_cmd_d = stat_cmd_q;
    end
    if (accept && !legal && (stat_err_q != 16'hFFFF)) begin
      stat_err_d = stat_err_q + 16'd1;
    end else begin
      stat_err_d = stat_err_q;
    end
  end

  // statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cmd_q <= 32'd0;
      stat_err_q <= 16'd0;
    end else begin
      stat_cmd_q <= stat_cmd_d;
      stat_err_q <= stat_err_d;
    end
  end

  assign stat_cmd_cnt = stat_cmd_q;
  assign stat_err_cnt = stat_err_q;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed self-checking bench: three issuers (ALU_LAT 0, 3, 4) with a small
// behavioural ALU attached to each.
module tb_alu_cmd_issuer;

  logic clk;
  logic rst;

  logic         cmd_valid  [3];
  logic         cmd_ready  [3];
  logic [3:0]   cmd_opcode [3];
  logic [127:0] cmd_a      [3];
  logic [127:0] cmd_b      [3];
  logic [4:0]   cmd_shift  [3];
  logic [3:0]   cmd_tag    [3];
  logic [3:0]   alu_opcode [3];
  logic [127:0] alu_input1 [3];
  logic [127:0] alu_input2 [3];
  logic [4:0]   alu_shift  [3];
  logic [127:0] alu_result [3];
  logic [3:0]   alu_flags  [3];
  logic         rsp_valid  [3];
  logic         rsp_ready  [3];
  logic [127:0] rsp_result [3];
  logic [3:0]   rsp_flags  [3];
  logic         rsp_err    [3];
  logic [3:0]   rsp_tag    [3];
  logic         busy       [3];
`ifdef ALU_ISSUER_STATS_EN
  logic [31:0]  stat_cmd_cnt [3];
  logic [15:0]  stat_err_cnt [3];
`endif

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] alu_model(input logic [3:0] op, input logic [127:0] a,
                                             input logic [127:0] b, input logic [4:0] sh);
    case (op)
      4'd0:    return (a < b) ? a : b;
      4'd1:    return a >> sh;
      4'd3:    return a | b;
      4'd4:    return a & b;
      4'd5:    return b;
      4'd6:    return ~(a | b);
      4'd8:    return a << sh;
      default: return 128'd0;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 3 : 4);
    assign alu_result[g] = alu_model(alu_opcode[g], alu_input1[g], alu_input2[g], alu_shift[g]);
    assign alu_flags[g]  = {alu_result[g][127], 1'b0, (alu_result[g] == 128'd0), 1'b0};
    alu_cmd_issuer #(.W(128), .SHW(5), .TAGW(4), .ALU_LAT(LAT), .MAX_OP(8)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid[g]),
      .cmd_ready  (cmd_ready[g]),
      .cmd_opcode (cmd_opcode[g]),
      .cmd_a      (cmd_a[g]),
      .cmd_b      (cmd_b[g]),
      .cmd_shift  (cmd_shift[g]),
      .cmd_tag    (cmd_tag[g]),
      .alu_opcode (alu_opcode[g]),
      .alu_input1 (alu_input1[g]),
      .alu_input2 (alu_input2[g]),
      .alu_shift  (alu_shift[g]),
      .alu_result (alu_result[g]),
      .alu_flags  (alu_flags[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_ready  (rsp_ready[g]),
      .rsp_result (rsp_result[g]),
      .rsp_flags  (rsp_flags[g]),
      .rsp_err    (rsp_err[g]),
      .rsp_tag    (rsp_tag[g]),
      .busy       (busy[g])
`ifdef ALU_ISSUER_STATS_EN
      ,
      .stat_cmd_cnt (stat_cmd_cnt[g]),
      .stat_err_cnt (stat_err_cnt[g])
`endif
    );
  end

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic [3:0] op, input logic [127:0] a,
                       input logic [127:0] b, input logic [4:0] sh, input logic [3:0] tag);
    cmd_valid[i]  = 1'b1;
    cmd_opcode[i] = op;
    cmd_a[i]      = a;
    cmd_b[i]      = b;
    cmd_shift[i]  = sh;
    cmd_tag[i]    = tag;
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmd_valid[i] = 1'b0; cmd_opcode[i] = 4'd0; cmd_a[i] = 128'd0; cmd_b[i] = 128'd0;
      cmd_shift[i] = 5'd0; cmd_tag[i] = 4'd0; rsp_ready[i] = 1'b1;
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset_cmd_ready", cmd_ready[0], 1);
    check("reset_busy", busy[0], 0);
    check("reset_rsp_valid", rsp_valid[0], 0);
    check("reset_alu_opcode", alu_opcode[0], 0);
    check("reset_rsp_tag", rsp_tag[0], 0);

    // OR on LAT=0: response seen at the second edge after accept
    drive(0, 4'd3, 128'hF0, 128'h0F, 5'd0, 4'd3);
    tick();
    cmd_valid[0] = 1'b0;
    check("or_busy", busy[0], 1);
    check("or_cmd_ready_low", cmd_ready[0], 0);
    check("or_valid_early", rsp_valid[0], 0);
    check("or_alu_opcode", alu_opcode[0], 3);
    tick();
    check("or_valid", rsp_valid[0], 1);
    check("or_result", rsp_result[0], 128'hFF);
    check("or_flags", rsp_flags[0], 4'b0000);
    check("or_tag", rsp_tag[0], 3);
    check("or_err", rsp_err[0], 0);
    tick();
    check("or_valid_drop", rsp_valid[0], 0);
    check("or_idle_ready", cmd_ready[0], 1);

    // AND with response stalled and a second command waiting
    rsp_ready[0] = 1'b0;
    drive(0, 4'd4, 128'hA, 128'h5, 5'd0, 4'd5);
    tick();
    drive(0, 4'd5, 128'h0, 128'h77, 5'd0, 4'd9);
    tick();
    check("and_valid", rsp_valid[0], 1);
    check("and_result", rsp_result[0], 0);
    check("and_flags", rsp_flags[0], 4'b0010);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("stall_valid", rsp_valid[0], 1);
      check("stall_tag", rsp_tag[0], 5);
      check("stall_cmd_ready", cmd_ready[0], 0);
      check("stall_alu_opcode", alu_opcode[0], 4);
    end
    rsp_ready[0] = 1'b1;
    tick();
    check("hs_valid_drop", rsp_valid[0], 0);
    check("hs_not_accepted", alu_opcode[0], 4);
    check("hs_cmd_ready", cmd_ready[0], 1);
    tick();
    cmd_valid[0] = 1'b0;
    check("second_accepted", alu_opcode[0], 5);
    check("second_busy", busy[0], 1);
    tick();
    check("second_result", rsp_result[0], 128'h77);
    check("second_tag", rsp_tag[0], 9);
    tick();

    // illegal opcode: immediate error response, ALU inputs untouched
    drive(0, 4'd12, 128'h1234, 128'h5678, 5'd3, 4'd7);
    tick();
    cmd_valid[0] = 1'b0;
    check("ill_valid", rsp_valid[0], 1);
    check("ill_err", rsp_err[0], 1);
    check("ill_result", rsp_result[0], 0);
    check("ill_flags", rsp_flags[0], 4'b0010);
    check("ill_tag", rsp_tag[0], 7);
    check("ill_alu_opcode", alu_opcode[0], 5);
    check("ill_alu_input2", alu_input2[0], 128'h77);
    tick();
    check("ill_valid_drop", rsp_valid[0], 0);
`ifdef ALU_ISSUER_STATS_EN
    check("stat_cmd", stat_cmd_cnt[0], 4);
    check("stat_err", stat_err_cnt[0], 1);
`endif

    // SLL on LAT=3: inputs held 4 cycles, response seen 5 edges after accept
    drive(1, 4'd8, 128'd1, 128'd0, 5'd31, 4'd2);
    tick();
    cmd_valid[1] = 1'b0;
    check("sll_alu_opcode", alu_opcode[1], 8);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("sll_wait_valid", rsp_valid[1], 0);
      check("sll_hold_shift", alu_shift[1], 31);
      check("sll_hold_a", alu_input1[1], 1);
    end
    tick();
    check("sll_valid", rsp_valid[1], 1);
    check("sll_result", rsp_result[1], 128'h8000_0000);
    check("sll_tag", rsp_tag[1], 2);
    tick();

    // LAT=4: reset during WAIT drops the command
    drive(2, 4'd0, 128'd5, 128'd9, 5'd0, 4'd6);
    tick();
    cmd_valid[2] = 1'b0;
    check("min_alu_a", alu_input1[2], 5);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy", busy[2], 0);
    check("rst_alu_a", alu_input1[2], 0);
    check("rst_alu_b", alu_input2[2], 0);
    check("rst_tag", rsp_tag[2], 0);
`ifdef ALU_ISSUER_STATS_EN
    check("stat_cmd_rst", stat_cmd_cnt[0], 0);
    check("stat_err_rst", stat_err_cnt[0], 0);
`endif
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rst_no_rsp", rsp_valid[2], 0);
    end
    drive(2, 4'd5, 128'd0, 128'h55, 5'd0, 4'd1);
    tick();
    cmd_valid[2] = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (rsp_valid[2]) begin
        cyc = k;
        break;
      end
    end
    check("passb_latency", cyc, 5);
    check("passb_result", rsp_result[2], 128'h55);
    check("passb_tag", rsp_tag[2], 1);
    check("passb_err", rsp_err[2], 0);
    tick();
    check("passb_valid_drop", rsp_valid[2], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
Initiator side of the ALU operand/result interface. Accepts tagged ALU commands over a valid/ready stream and drives opcode, operands and shift amount into an attached ALU. Holds those inputs stable for a fixed settle time, then captures the result and flags and returns them as a tagged valid/ready response. It sits between a command source (test sequencer or microcode engine) and any generated ALU instance.

Parameters:
- W, 128, operand/result width
- SHW, 5, shift-amount width
- TAGW, 4, command tag width
- ALU_LAT, 0, extra settle cycles the ALU inputs are held before capture (0..15)
- MAX_OP, 8, highest legal opcode; opcodes above this are illegal

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_opcode  in  4  ALU opcode
- cmd_a  in  W  operand 1
- cmd_b  in  W  operand 2
- cmd_shift  in  SHW  shift amount
- cmd_tag  in  TAGW  tag echoed on response
- alu_opcode  out  4  to ALU opcode
- alu_input1  out  W  to ALU input1
- alu_input2  out  W  to ALU input2
- alu_shift  out  SHW  to ALU shiftValue
- alu_result  in  W  from ALU result
- alu_flags  in  4  from ALU {sign, overflow, zero, carry}
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_result  out  W  captured result
- rsp_flags  out  4  captured {sign, overflow, zero, carry}
- rsp_err  out  1  illegal opcode
- rsp_tag  out  TAGW  echoed tag
- busy  out  1  state != IDLE

Behaviour:
- One clock, clk; reset rst is synchronous and active-high. It returns state to IDLE, zeroes every output register (alu_*, rsp_*, busy) and clears the wait counter.
- FSM states: IDLE, WAIT, RESP.
- cmd_ready = (state == IDLE) and not rst. Accept = cmd_valid && cmd_ready.
- IDLE, on accept:
  - Register opcode/a/b/shift into the alu_* output regs and the tag into a tag reg.
  - Legal opcode (<= MAX_OP): load cnt = ALU_LAT and go to WAIT.
  - Illegal opcode: leave alu_* unchanged. Load rsp_result = 0, rsp_flags = 4'b0010 (zero only), rsp_err = 1. Go to RESP.
- WAIT:
  - alu_* held constant.
  - cnt != 0: decrement.
  - cnt == 0: capture alu_result into rsp_result and alu_flags into rsp_flags, set rsp_err = 0, go to RESP.
- RESP:
  - rsp_valid = 1; all rsp_* held stable until rsp_ready.
  - On handshake go to IDLE; rsp_valid drops the next cycle.
  - No new command is accepted in RESP (cmd_ready low). A new command can be accepted the cycle after the handshake.
- Latency, accept at edge N:
  - Legal op: rsp_valid is high from edge N+2+ALU_LAT.
  - Illegal op: rsp_valid is high from edge N+1.
- Throughput with rsp_ready tied high: one legal command per ALU_LAT+3 cycles.
- alu_* keep the last issued values in IDLE/RESP (no glitching to 0), so the ALU result stays observable.
- Reset mid-WAIT or mid-RESP drops the in-flight command: no response, and the tag is discarded.
- cmd_valid with rsp_ready both high in RESP: the response completes; the command is not accepted that cycle.

Optional Feature:
- Macro ALU_ISSUER_STATS_EN.
- Defined: adds outputs stat_cmd_cnt[31:0] and stat_err_cnt[15:0].
  - stat_cmd_cnt increments on every accept; stat_err_cnt increments on every illegal-opcode accept.
  - Both saturate at all-ones and clear on rst.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (MIN=0, SRL=1, ROR=2, OR=3, AND=4, PASSB=5, NOR=6, SGE=7, SLL=8)
  - flag bit indices (CARRY=0, ZERO=1, OVF=2, SIGN=3)
  - FSM state typedef
- Sub-module alu_issue_wait_ctr: loadable 4-bit down-counter with done output. This is the only natural split; the FSM stays in the top.

Test Plan:
- ALU_LAT=0, bench ALU model, cmd OR a=0xF0 b=0x0F tag=3 -> rsp_valid 2 cycles after accept, rsp_result=0xFF, rsp_flags=4'b0000, rsp_tag=3, rsp_err=0.
- ALU_LAT=3, cmd SLL a=1 shift=127-bit... use shift=31, a=1 -> alu_* stable for 4 cycles, rsp_result=1<<31, rsp_valid 5 cycles after accept.
- AND a=0xA b=0x5, rsp_ready held low 6 cycles with a second cmd_valid pending -> rsp_* stable, cmd_ready low, second command accepted only the cycle after handshake.
- opcode=4'd12 tag=7 -> rsp_valid 1 cycle after accept, rsp_err=1, rsp_result=0, rsp_flags=4'b0010, alu_* unchanged.
- ALU_LAT=4, rst pulsed during WAIT -> no rsp_valid, all outputs 0, busy=0; next PASSB b=0x55 completes normally with result 0x55.
- With ALU_ISSUER_STATS_EN: 3 legal + 1 illegal command -> stat_cmd_cnt=4, stat_err_cnt=1; after rst both 0.
